ram_pattern_master: RTL and testbench
=====================================

// Module: ram_pattern_master
// PURPOSE
//  Initiator for the small byte-wide scratch RAM: drives address, write data and write enable, and
//  samples the RAM's combinational read port. On start it writes a selected pattern to every address,
//  reads all addresses back and compares against the regenerated pattern. It reports pass/fail, the
//  error count and the first failing address, serving as on-chip self-test and bring-up stimulus.
// PARAMETERS
//  ADDR_BITS     5  RAM address width; NUM_BYTES = 2**ADDR_BITS.
//  STOP_ON_FAIL  0  1: end the read phase on the first mismatch; 0: scan all addresses.
// PORTS
//  clk             in   1            single clock; all state updates on posedge.
//  rst             in   1            synchronous, active-high reset.
//  start           in   1            level-sampled; accepted only in IDLE.
//  pattern_sel     in   2            0 addr^seed, 1 LFSR, 2 checkerboard, 3 constant seed.
//  seed            in   8            pattern seed; sampled with start.
//  mem_addr        out  ADDR_BITS    RAM address.
//  mem_wdata       out  8            RAM write data.
//  mem_we          out  1            RAM write enable; RAM writes on the clk edge when high.
//  mem_rdata       in   8            RAM read data for mem_addr, same cycle (combinational).
//  busy            out  1            high in WRITE and READ.
//  done            out  1            one-cycle pulse when a run completes.
//  pass            out  1            1 if err_count==0 for the last run.
//  err_count       out  ADDR_BITS+1  mismatches in the last run (max NUM_BYTES, no saturation).
//  first_fail_addr out  ADDR_BITS    address of first mismatch; 0 if none.
// BEHAVIOUR
//  Reset: state IDLE; mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, pass=0, err_count=0,
//   first_fail_addr=0. Reset mid-run aborts at once; mem_we is low in the cycle after rst.
//  FSM: IDLE -start-> WRITE -(addr==NUM_BYTES-1)-> READ -(addr==NUM_BYTES-1, or mismatch with
//   STOP_ON_FAIL=1)-> DONE -> IDLE. start during WRITE/READ/DONE is ignored.
//  Start accept (cycle 0): latch pattern_sel/seed; clear err_count, first_fail_addr, pass.
//  WRITE: cycles 1..N; mem_we=1, mem_addr=k in cycle k+1, mem_wdata=P(k).
//  READ: cycles N+1..2N; mem_we=0, mem_addr=k, compare mem_rdata with P(k) in the same cycle.
//   On mismatch: err_count++; if first, first_fail_addr=k.
//  DONE: cycle 2N+1 (full scan); done=1 and pass=(err_count==0) valid. Results hold until next accept.
//  STOP_ON_FAIL=1: mismatch at read address k -> DONE in the next cycle.
//  Outside WRITE/READ: mem_addr=0, mem_wdata=0, mem_we=0.
//  Patterns, k = address zero-extended to 8 bits:
//   0: P(k)=k ^ seed.   2: P(k)=0x55 for even k, 0xAA for odd k.   3: P(k)=seed.
//   1: 8-bit Galois LFSR, taps x^8+x^6+x^5+x^4+1 (mask 0xB8). P(0)=seed; seed 0 is
//    replaced by 0x01. Advance once per address. Reload at the start of both WRITE and READ
//    so the READ sequence is identical.
//  Address counter: ADDR_BITS wide; wraps to 0 on the WRITE->READ transition; never wraps within a phase.
//  busy falls in the DONE cycle. done and busy are never both high.
// STRUCTURE
//  Package ram_pattern_pkg: state enum {IDLE, WRITE, READ, DONE}, pattern codes PAT_ADDR/PAT_LFSR/
//   PAT_CHECK/PAT_CONST, LFSR_MASK=8'hB8, checkerboard constants 8'h55/8'hAA.
//  Sub-module ram_pattern_gen: inputs sel, seed, load, step, addr; output data = P(addr).
//   It holds the LFSR state. Top level keeps the FSM, address counter, comparator and result registers.
// TESTING (bench uses a behavioural 32x8 RAM with fault-injection hooks)
//  pattern 0, seed 0x00, clean RAM -> done at cycle 65; pass=1; err_count=0; RAM[k]==k for all k.
//  pattern 1, seed 0x00 -> RAM[0]=0x01, RAM[1]=0xB8 (Galois step); readback pass=1.
//  pattern 2, bit 3 of address 7 stuck at 0 -> err_count=1, first_fail_addr=7, pass=0.
//  STOP_ON_FAIL=1, pattern 3 seed 0xFF, addr 4 and 9 stuck 0x00 -> done at cycle 38; err_count=1; fail addr 4.
//  start held high for the whole run -> exactly one run; start pulsed mid-READ -> ignored.
//  rst asserted in cycle 10 of WRITE -> next cycle mem_we=0, busy=0, outputs at reset values; new start runs clean.

Source files
------------

// File: rtl/ram_pattern_pkg.sv
// rtl/ram_pattern_pkg.sv - shared types, pattern codes and LFSR helpers for the RAM pattern master
// Contents:
//   state_e      FSM states IDLE/WRITE/READ/DONE
//   PAT_*        pattern_sel encodings
//   LFSR_MASK    Galois feedback mask for x^8+x^6+x^5+x^4+1
//   CHECK_*      checkerboard bytes for even/odd addresses
//   lfsr_seed()  seed sanitiser (an all-zero LFSR would lock up)
//   lfsr_next()  one Galois LFSR step
package ram_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_LFSR  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    localparam logic [7:0] LFSR_MASK  = 8'hB8;
    localparam logic [7:0] CHECK_EVEN = 8'h55;
    localparam logic [7:0] CHECK_ODD  = 8'hAA;

    function automatic logic [7:0] lfsr_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/ram_pattern_gen.sv
// rtl/ram_pattern_gen.sv - pattern generator producing P(addr) for the selected test pattern
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   sel       pattern select (PAT_ADDR/PAT_LFSR/PAT_CHECK/PAT_CONST)
//   seed      pattern seed
//   load      reload the LFSR from seed (takes priority over step)
//   step      advance the LFSR by one address
//   addr      current RAM address
//   data      pattern byte for addr
module ram_pattern_gen
    import ram_pattern_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           sel,
    input  logic [7:0]           seed,
    input  logic                 load,
    input  logic                 step,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [7:0]           data
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] addr_ext;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = lfsr_seed(seed);
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The LFSR value tracks the address because it is reloaded at address 0
    // and stepped exactly once per address within a phase.
    always_comb begin
        addr_ext                = 8'h00;
        addr_ext[ADDR_BITS-1:0] = addr;
        case (sel)
            PAT_ADDR:  data = addr_ext ^ seed;
            PAT_LFSR:  data = lfsr_q;
            PAT_CHECK: data = addr[0] ? CHECK_ODD : CHECK_EVEN;
            default:   data = seed;
        endcase
    end

endmodule

// File: rtl/ram_pattern_master.sv
// rtl/ram_pattern_master.sv - RAM self-test initiator: write pattern, read back, compare, report
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            level-sampled run request, accepted only in IDLE
//   pattern_sel      0 addr^seed, 1 LFSR, 2 checkerboard, 3 constant seed
//   seed             pattern seed, latched with start
//   mem_addr         RAM address (0 outside WRITE/READ)
//   mem_wdata        RAM write data (0 outside WRITE)
//   mem_we           RAM write enable (WRITE only)
//   mem_rdata        combinational RAM read data for mem_addr
//   busy             high in WRITE and READ
//   done             one-cycle pulse in DONE
//   pass             last run had no mismatches
//   err_count        mismatches in the last run
//   first_fail_addr  address of the first mismatch, 0 if none
module ram_pattern_master
    import ram_pattern_pkg::*;
#(
    parameter int ADDR_BITS    = 5,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           pattern_sel,
    input  logic [7:0]           seed,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_BITS:0]   err_count,
    output logic [ADDR_BITS-1:0] first_fail_addr
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q,  addr_d;
    logic [1:0]           sel_q,   sel_d;
    logic [7:0]           seed_q,  seed_d;
    logic [ADDR_BITS:0]   err_q,   err_d;
    logic [ADDR_BITS-1:0] ffa_q,   ffa_d;
    logic                 pass_q,  pass_d;

    logic       gen_load;
    logic       gen_step;
    logic [7:0] gen_seed;
    logic [7:0] gen_data;
    logic       mismatch;

    // Generator control is kept apart from the main FSM block so that it does
    // not depend on gen_data, which would otherwise form a block-level loop.
    always_comb begin
        gen_seed = (state_q == IDLE) ? seed : seed_q;
        gen_load = ((state_q == IDLE) && start) ||
                   ((state_q == WRITE) && (addr_q == LAST_ADDR));
        gen_step = (state_q == WRITE) || (state_q == READ);
    end

    ram_pattern_gen #(
        .ADDR_BITS(ADDR_BITS)
    ) u_gen (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel_q),
        .seed (gen_seed),
        .load (gen_load),
        .step (gen_step),
        .addr (addr_q),
        .data (gen_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        seed_d    = seed_q;
        err_d     = err_q;
        ffa_d     = ffa_q;
        pass_d    = pass_q;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mismatch  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    addr_d  = '0;
                    sel_d   = pattern_sel;
                    seed_d  = seed;
                    err_d   = '0;
                    ffa_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = gen_data;
                if (addr_q == LAST_ADDR) begin
                    state_d = READ;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_addr = addr_q;
                mismatch = (mem_rdata != gen_data);
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ffa_d = addr_q;
                    end
                end
                // pass is resolved here, from the count including this
                // cycle's compare, so it is already valid during DONE.
                if ((addr_q == LAST_ADDR) || ((STOP_ON_FAIL != 0) && mismatch)) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= PAT_ADDR;
            seed_q  <= 8'h00;
            err_q   <= '0;
            ffa_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            ffa_q   <= ffa_d;
            pass_q  <= pass_d;
        end
    end

    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_ram_pattern_master.sv
// tb/tb_ram_pattern_master.sv - self-checking bench for ram_pattern_master (both STOP_ON_FAIL settings)
module tb_ram_pattern_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] pattern_sel;
    logic [7:0] seed;
    logic [7:0] stuck_mask [32];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference pattern value straight from the pattern definitions.
    function automatic logic [7:0] pat_val(input logic [1:0] sel, input logic [7:0] sd, input int k);
        logic [7:0] s;
        case (sel)
            2'd0: return 8'(k) ^ sd;
            2'd1: begin
                s = (sd == 8'h00) ? 8'h01 : sd;
                for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
                return s;
            end
            2'd2: return (k % 2 == 1) ? 8'hAA : 8'h55;
            default: return sd;
        endcase
    endfunction

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_inst
        logic [4:0] mem_addr;
        logic [7:0] mem_wdata;
        logic [7:0] mem_rdata;
        logic       mem_we;
        logic       busy;
        logic       done;
        logic       pass;
        logic [5:0] err_count;
        logic [4:0] first_fail_addr;
        logic [7:0] ram [32];

        ram_pattern_master #(
            .ADDR_BITS    (5),
            .STOP_ON_FAIL (gi)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start),
            .pattern_sel     (pattern_sel),
            .seed            (seed),
            .mem_addr        (mem_addr),
            .mem_wdata       (mem_wdata),
            .mem_we          (mem_we),
            .mem_rdata       (mem_rdata),
            .busy            (busy),
            .done            (done),
            .pass            (pass),
            .err_count       (err_count),
            .first_fail_addr (first_fail_addr)
        );

        // Behavioural RAM with stuck-at-zero bits applied on the read path.
        assign mem_rdata = ram[mem_addr] & ~stuck_mask[mem_addr];
        always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

        // Model: m_t counts cycles since the accept cycle (1..32 write,
        // 33..32+m_len read, 33+m_len done).
        bit         m_act = 1'b0;
        int         m_t = 0;
        int         m_len = 32;
        int         m_err = 0;
        int         m_ffa = 0;
        bit         m_pass = 1'b0;
        int         ffirst = -1;
        logic [7:0] m_pat [32];
        bit         m_fail [32];

        always @(posedge clk) begin
            if (rst) begin
                m_act = 1'b0; m_t = 0; m_err = 0; m_ffa = 0; m_pass = 1'b0;
            end else if (!m_act) begin
                if (start) begin
                    ffirst = -1;
                    for (int k = 0; k < 32; k++) begin
                        m_pat[k]  = pat_val(pattern_sel, seed, k);
                        m_fail[k] = ((m_pat[k] & ~stuck_mask[k]) != m_pat[k]);
                        if (m_fail[k] && ffirst < 0) ffirst = k;
                    end
                    m_len  = (gi != 0 && ffirst >= 0) ? ffirst + 1 : 32;
                    m_act  = 1'b1; m_t = 1;
                    m_err  = 0; m_ffa = 0; m_pass = 1'b0;
                end
            end else begin
                m_t++;
                if (m_t == 33 + m_len) begin
                    m_err = 0;
                    for (int k = 0; k < m_len; k++) if (m_fail[k]) m_err++;
                    m_ffa  = (ffirst < 0) ? 0 : ffirst;
                    m_pass = (m_err == 0);
                end else if (m_t > 33 + m_len) begin
                    m_act = 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            int e_addr, e_wd, e_err, e_ffa, rd;
            bit e_we, e_busy, e_done, e_pass, run;
            if (chk_en) begin
                e_addr = 0; e_wd = 0; e_we = 0; e_busy = 0; e_done = 0; run = 0; rd = 0;
                e_err = m_err; e_ffa = m_ffa; e_pass = m_pass;
                if (m_act) begin
                    if (m_t <= 32) begin
                        e_we = 1; e_busy = 1; e_addr = m_t - 1; e_wd = m_pat[m_t-1]; run = 1; rd = 0;
                    end else if (m_t < 33 + m_len) begin
                        e_busy = 1; e_addr = m_t - 33; run = 1; rd = m_t - 33;
                    end else begin
                        e_done = 1;
                    end
                end
                if (run) begin
                    e_err = 0;
                    for (int k = 0; k < rd; k++) if (m_fail[k]) e_err++;
                    e_ffa  = (e_err > 0) ? ffirst : 0;
                    e_pass = 1'b0;
                end
                chk($sformatf("inst%0d mem_we t=%0d", gi, m_t), int'(mem_we), int'(e_we));
                chk($sformatf("inst%0d mem_addr t=%0d", gi, m_t), int'(mem_addr), e_addr);
                chk($sformatf("inst%0d busy t=%0d", gi, m_t), int'(busy), int'(e_busy));
                chk($sformatf("inst%0d done t=%0d", gi, m_t), int'(done), int'(e_done));
                chk($sformatf("inst%0d pass t=%0d", gi, m_t), int'(pass), int'(e_pass));
                chk($sformatf("inst%0d err_count t=%0d", gi, m_t), int'(err_count), e_err);
                chk($sformatf("inst%0d first_fail_addr t=%0d", gi, m_t), int'(first_fail_addr), e_ffa);
                if (e_we || !e_busy)
                    chk($sformatf("inst%0d mem_wdata t=%0d", gi, m_t), int'(mem_wdata), e_wd);
            end
        end
    end

    task automatic run_start(input logic [1:0] sel, input logic [7:0] sd);
        @(negedge clk); #1;
        pattern_sel = sel; seed = sd; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles (accept cycle = 0) until the chosen instance pulses done.
    task automatic wait_done(input int which, inout int cyc);
        while (((which == 0) ? g_inst[0].done : g_inst[1].done) !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int cnt;

    initial begin
        rst = 1'b1; start = 1'b0; pattern_sel = 2'd0; seed = 8'h00;
        for (int k = 0; k < 32; k++) stuck_mask[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", int'(g_inst[0].busy), 0);
        chk("reset mem_we", int'(g_inst[0].mem_we), 0);
        chk("reset pass", int'(g_inst[0].pass), 0);
        chk("reset err_count", int'(g_inst[0].err_count), 0);
        #1 rst = 1'b0;

        // Pattern 0, seed 0, clean RAM.
        run_start(2'd0, 8'h00);
        cyc = 1; wait_done(0, cyc);
        chk("p0 done cycle", cyc, 65);
        chk("p0 pass", int'(g_inst[0].pass), 1);
        chk("p0 err_count", int'(g_inst[0].err_count), 0);
        for (int k = 0; k < 32; k++) chk($sformatf("p0 ram[%0d]", k), int'(g_inst[0].ram[k]), k);

        // Pattern 1 (LFSR), seed 0 replaced by 0x01.
        run_start(2'd1, 8'h00);
        cyc = 1; wait_done(0, cyc);
        chk("lfsr ram[0]", int'(g_inst[0].ram[0]), 8'h01);
        chk("lfsr ram[1]", int'(g_inst[0].ram[1]), 8'hB8);
        chk("lfsr ram[2]", int'(g_inst[0].ram[2]), 8'h5C);
        chk("lfsr pass", int'(g_inst[0].pass), 1);

        // Checkerboard, bit 3 of address 7 stuck at 0.
        stuck_mask[7] = 8'h08;
        run_start(2'd2, 8'h00);
        cyc = 1; wait_done(0, cyc);
        chk("chk err_count", int'(g_inst[0].err_count), 1);
        chk("chk first_fail", int'(g_inst[0].first_fail_addr), 7);
        chk("chk pass", int'(g_inst[0].pass), 0);

        // Constant 0xFF, addresses 4 and 9 stuck at 0x00.
        stuck_mask[7] = 8'h00; stuck_mask[4] = 8'hFF; stuck_mask[9] = 8'hFF;
        run_start(2'd3, 8'hFF);
        cyc = 1; wait_done(1, cyc);
        chk("sof done cycle", cyc, 38);
        chk("sof err_count", int'(g_inst[1].err_count), 1);
        chk("sof first_fail", int'(g_inst[1].first_fail_addr), 4);
        wait_done(0, cyc);
        chk("full done cycle", cyc, 65);
        chk("full err_count", int'(g_inst[0].err_count), 2);
        chk("full first_fail", int'(g_inst[0].first_fail_addr), 4);
        stuck_mask[4] = 8'h00; stuck_mask[9] = 8'h00;

        // start held through a whole run gives exactly one run.
        @(negedge clk); #1;
        pattern_sel = 2'd0; seed = 8'h3C; start = 1'b1;
        cnt = 0;
        repeat (66) begin
            @(negedge clk);
            if (g_inst[0].done) cnt++;
        end
        #1 start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (g_inst[0].done) cnt++;
        end
        chk("held start runs", cnt, 1);

        // start pulsed mid-READ is ignored.
        run_start(2'd2, 8'h00);
        cyc = 1;
        repeat (39) begin @(negedge clk); cyc++; end
        #1 start = 1'b1;
        @(negedge clk); cyc++;
        #1 start = 1'b0;
        wait_done(0, cyc);
        chk("mid-read start done cycle", cyc, 65);

        // Reset in cycle 10 of WRITE aborts at once.
        run_start(2'd0, 8'h5A);
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort mem_we", int'(g_inst[0].mem_we), 0);
        chk("abort busy", int'(g_inst[0].busy), 0);
        chk("abort pass", int'(g_inst[0].pass), 0);
        chk("abort mem_addr", int'(g_inst[0].mem_addr), 0);
        #1 rst = 1'b0;
        run_start(2'd0, 8'h11);
        cyc = 1; wait_done(0, cyc);
        chk("rerun done cycle", cyc, 65);
        chk("rerun pass", int'(g_inst[0].pass), 1);
        chk("rerun ram[3]", int'(g_inst[0].ram[3]), 8'h12);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
